// File: rtl/mac_dot_ctrl.sv
// Operand sequencer for the 8x8 MAC: buffers (a,b) pairs, issues one pair per
// cycle until vec_len products are consumed, then captures and hands off the sum.
module mac_dot_ctrl #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [LEN_W-1:0] vec_len,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  output logic             mac_clr,
  input  logic [16:0]      mac_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [16:0]      out_data,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_CAPT, S_HOLD, S_CLR} state_t;

  pair_t            r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  state_t           r_state;
  logic [LEN_W-1:0] r_len, r_cnt;

  logic             w_full, w_empty, w_push, w_pop;
  logic [LEN_W-1:0] w_cnt_nxt;
  pair_t            w_head;

  // Full comes from the registered count only, so a same-cycle pop never frees a slot.
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_push    = in_valid & ~w_full;
  assign w_pop     = (r_state == S_RUN) & ~w_empty;
  assign w_head    = r_mem[r_rptr];
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign in_ready  = ~w_full;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {in_a, in_b};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_cnt     <= '0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_clr   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      // Operands are zero unless this edge pops, so idle cycles add nothing to the sum.
      mac_a   <= '0;
      mac_b   <= '0;
      mac_clr <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_len   <= vec_len;
            r_cnt   <= '0;
            r_state <= (vec_len == '0) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (w_pop) begin
            mac_a <= w_head.a;
            mac_b <= w_head.b;
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_len) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: r_state <= S_CAPT;
        S_CAPT: begin
          out_data  <= mac_result;
          out_valid <= 1'b1;
          r_state   <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            mac_clr   <= 1'b1;
            r_state   <= S_CLR;
          end
        end
        S_CLR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  a_clr_pulse: assert property (@(posedge clk) disable iff (reset) mac_clr |=> !mac_clr);
  a_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule
